cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_controller_if.sv | 29 ++
 rtl/cpu_controller.sv | 114 +++++++++++
 tb/tb_cpu_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_controller_if.sv
// Controller <-> datapath signal bundle: opcode/flags in, strobes and debug out.
interface cpu_controller_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [2:0]       opcode;
  logic             acc_z;
  logic             go;
  logic             jump;
  logic             acc_src;
  logic             acc_wr;
  logic             pc_en;
  logic             mem_rd;
  logic             mem_wr;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  // Datapath side: drives opcode/flags, receives strobes.
  modport master (
    output opcode, acc_z, go,
    input  jump, acc_src, acc_wr, pc_en, mem_rd, mem_wr, halted, state, instr_cnt
  );

  // Controller side.
  modport slave (
    input  opcode, acc_z, go,
    output jump, acc_src, acc_wr, pc_en, mem_rd, mem_wr, halted, state, instr_cnt
  );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/UPDATE(/SKIP), HALT with go-resume.
module cpu_controller #(
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  cpu_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_SKIP   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  state_t           state_q;
  logic [2:0]       op_q;
  logic             z_q;
  logic [CNT_W-1:0] cnt_q;

  logic is_alu;
  logic reads_mem;

  assign is_alu    = (op_q == OP_ADD) || (op_q == OP_AND) || (op_q == OP_XOR);
  assign reads_mem = is_alu || (op_q == OP_LDA);

  // Sequencer state, opcode/flag latches and saturating retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= 3'd0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          op_q    <= bus.opcode;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (op_q == OP_HLT) begin
            state_q <= S_HALT;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_q == OP_SKZ) z_q <= bus.acc_z;
          state_q <= (op_q == OP_JMP) ? S_FETCH : S_UPDATE;
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
        S_UPDATE: state_q <= ((op_q == OP_SKZ) && z_q) ? S_SKIP : S_FETCH;
        S_SKIP:   state_q <= S_FETCH;
        S_HALT:   if (bus.go) state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Strobes decoded from current state and latched opcode; forced low while in reset.
  always_comb begin
    bus.jump    = 1'b0;
    bus.acc_src = 1'b0;
    bus.acc_wr  = 1'b0;
    bus.pc_en   = 1'b0;
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.halted  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_DECODE: bus.mem_rd = reads_mem;
        S_EXEC: begin
          if (is_alu) begin
            bus.mem_rd = 1'b1;
            bus.acc_wr = 1'b1;
          end else if (op_q == OP_LDA) begin
            bus.mem_rd  = 1'b1;
            bus.acc_src = 1'b1;
            bus.acc_wr  = 1'b1;
          end else if (op_q == OP_STO) begin
            bus.mem_wr = 1'b1;
          end else if (op_q == OP_JMP) begin
            bus.jump  = 1'b1;
            bus.pc_en = 1'b1;
          end
        end
        S_UPDATE, S_SKIP: bus.pc_en = 1'b1;
        S_HALT: begin
          bus.halted = 1'b1;
          bus.pc_en  = bus.go;
        end
        default: ;
      endcase
    end
  end

  // Debug state and counter views.
  assign bus.state     = 3'(state_q);
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized instruction-stream bench with an instruction-level expected-trace model.
module tb_cpu_controller;

  localparam int unsigned CNT_W = 4;
  localparam int MAXC = (1 << CNT_W) - 1;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3,
                         XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  typedef struct packed {
    logic       jump;
    logic       acc_src;
    logic       acc_wr;
    logic       pc_en;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic [2:0] state;
  } outs_t;

  logic clk = 1'b0;
  logic rst;

  cpu_controller_if #(.CNT_W(CNT_W)) bus ();

  cpu_controller #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  bit    chk_en = 1'b0;
  outs_t exp_o;
  int    exp_cnt;
  int    m_cnt = 0;
  int    g_n;
  int    g_rst_at;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic logic [2:0] ro();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Per-cycle comparison of every DUT output against the model's expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      outs_t act;
      act = {bus.jump, bus.acc_src, bus.acc_wr, bus.pc_en, bus.mem_rd,
             bus.mem_wr, bus.halted, bus.state};
      chk("outputs", int'(act), int'(exp_o));
      chk("instr_cnt", int'(bus.instr_cnt), exp_cnt);
    end
  end

  // One clock of stimulus; reset replaces the planned strobes with zeros and aborts.
  task automatic adv(input outs_t o, input logic [2:0] op_in, input logic z_in,
                     input logic go_in, output bit ab);
    ab = (g_n == g_rst_at);
    rst = ab;
    bus.opcode = op_in;
    bus.acc_z  = z_in;
    bus.go     = go_in;
    exp_o = o;
    if (ab) begin
      exp_o = '0;
      exp_o.state = o.state;
    end
    exp_cnt = m_cnt;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    g_n++;
    if (ab) m_cnt = 0;
  endtask

  // Plays one instruction and returns its cycle count (-1 if reset cut it short).
  task automatic run_instr(input logic [2:0] op, input int rst_at, input int halt_wait,
                           input int zf, output int ncyc);
    outs_t o;
    bit    ab;
    logic  z_exec;
    ncyc = -1;
    g_n = 0;
    g_rst_at = rst_at;
    z_exec = (zf < 0) ? rb() : zf[0];

    o = '0;
    adv(o, op, rb(), rb(), ab);
    if (ab) return;

    o = '0;
    o.state  = 3'd1;
    o.mem_rd = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
    adv(o, ro(), rb(), rb(), ab);
    if (ab) return;

    if (op == HLT) begin
      m_cnt = sat(m_cnt + 1);
      for (int i = 0; i < halt_wait; i++) begin
        o = '0;
        o.state  = 3'd5;
        o.halted = 1'b1;
        adv(o, ro(), rb(), 1'b0, ab);
        if (ab) return;
      end
      o = '0;
      o.state  = 3'd5;
      o.halted = 1'b1;
      o.pc_en  = 1'b1;
      adv(o, ro(), rb(), 1'b1, ab);
      if (ab) return;
      ncyc = g_n;
      return;
    end

    o = '0;
    o.state = 3'd2;
    case (op)
      ADD, AND_, XOR_: begin o.mem_rd = 1'b1; o.acc_wr = 1'b1; end
      LDA:             begin o.mem_rd = 1'b1; o.acc_src = 1'b1; o.acc_wr = 1'b1; end
      STO:             o.mem_wr = 1'b1;
      JMP:             begin o.jump = 1'b1; o.pc_en = 1'b1; end
      default: ;
    endcase
    adv(o, ro(), z_exec, rb(), ab);
    if (ab) return;
    m_cnt = sat(m_cnt + 1);
    if (op == JMP) begin
      ncyc = g_n;
      return;
    end

    o = '0;
    o.state = 3'd3;
    o.pc_en = 1'b1;
    adv(o, ro(), rb(), rb(), ab);
    if (ab) return;

    if ((op == SKZ) && z_exec) begin
      o = '0;
      o.state = 3'd4;
      o.pc_en = 1'b1;
      adv(o, ro(), rb(), rb(), ab);
      if (ab) return;
    end
    ncyc = g_n;
  endtask

  initial begin
    outs_t o;
    bit    ab;
    int    n;
    logic [2:0] op;
    int    ra;

    rst = 1'b1;
    bus.opcode = 3'd0;
    bus.acc_z  = 1'b0;
    bus.go     = 1'b0;
    @(posedge clk);
    #1;

    // Reset held: all strobes low, FETCH, counter zero.
    g_n = 0;
    g_rst_at = 0;
    o = '0;
    adv(o, 3'd0, 1'b0, 1'b1, ab);

    run_instr(LDA, -1, 0, -1, n);
    chk("lda_cycles", n, 4);
    chk("lda_cnt_model", m_cnt, 1);

    run_instr(JMP, -1, 0, -1, n);
    chk("jmp_cycles", n, 3);

    run_instr(SKZ, -1, 0, 1, n);
    chk("skz_taken_cycles", n, 5);
    run_instr(SKZ, -1, 0, 0, n);
    chk("skz_not_taken_cycles", n, 4);

    run_instr(HLT, -1, 10, -1, n);
    chk("hlt_cycles", n, 13);

    run_instr(STO, -1, 0, -1, n);
    run_instr(ADD, -1, 0, -1, n);
    chk("cnt_after_directed", m_cnt, 7);

    run_instr(ADD, 2, 0, -1, n);
    chk("rst_in_exec_cnt_model", m_cnt, 0);
    run_instr(ADD, -1, 0, -1, n);
    run_instr(SKZ, 4, 0, 1, n);
    run_instr(HLT, 3, 5, -1, n);
    run_instr(HLT, 4, 2, -1, n);
    run_instr(XOR_, -1, 0, -1, n);

    // Randomized instruction stream with occasional mid-instruction resets.
    for (int k = 0; k < 250; k++) begin
      op = ro();
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_instr(op, ra, int'($urandom_range(0, 3)), -1, n);
    end

    // Counter saturation after a clean reset.
    run_instr(ADD, 0, 0, -1, n);
    for (int k = 0; k < 20; k++) run_instr(ADD, -1, 0, -1, n);
    chk("sat_model", m_cnt, 15);
    chk("sat_dut", int'(bus.instr_cnt), 15);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
